booth_r4_seq_mult: RTL

Parametrised sequential radix-4 Booth multiplier that retires one Booth digit per clock. Supports signed and unsigned operands under a per-operation mode bit, and uses a start/done handshake. It is the general multiply engine for datapaths wider than 8 bits and for mixed signed/unsigned arithmetic. It sits between an operand-issuing controller and a result consumer that samples on `done`.

---
 rtl/booth_pkg.sv | 36 +++
 rtl/booth_r4_digit_enc.sv | 16 +
 rtl/booth_r4_seq_mult.sv | 131 +++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multipliers.
// Holds the control-state encoding, the digit-select encoding and the digit-count rule.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } digit_sel_e;

    // One extra digit beyond WIDTH/2 so unsigned operands with the MSB set stay exact.
    function automatic int booth_digits(input int width);
        return width / 2 + 1;
    endfunction

    function automatic digit_sel_e digit_sel(input logic zero, input logic two, input logic neg);
        digit_sel_e sel;
        if (zero) begin
            sel = ZERO;
        end else if (neg) begin
            sel = two ? NEG2 : NEG1;
        end else begin
            sel = two ? POS2 : POS1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/booth_r4_digit_enc.sv
// Radix-4 Booth digit decoder: {b[2k+1], b[2k], b[2k-1]} -> {zero, two, neg}.
// Purely combinational so it can be replicated by a parallel multiplier.
module booth_r4_digit_enc (
    input  logic [2:0] triplet_i,
    output logic       zero_o,
    output logic       two_o,
    output logic       neg_o
);

    always_comb begin
        zero_o = (triplet_i == 3'b000) || (triplet_i == 3'b111);
        two_o  = (triplet_i == 3'b011) || (triplet_i == 3'b100);
        neg_o  = triplet_i[2] && !zero_o;
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier retiring one digit per clock, signed or unsigned per op.
// Multiplicand and multiplier are shifted in place so each digit reads fixed bit positions.
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N  = booth_digits(WIDTH);
    localparam int AW = 2 * WIDTH + 2;
    localparam int BW = WIDTH + 3;
    localparam int CW = $clog2(N + 1);

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [AW-1:0]      mcand_q;
    logic [BW-1:0]      mplier_q;
    logic [AW-1:0]      acc_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] product_q;

    logic [AW-1:0]      mcand_d;
    logic [BW-1:0]      mplier_d;
    logic [AW-1:0]      acc_d;
    logic [CW-1:0]      cnt_d;
    logic [AW-1:0]      mcand_init;
    logic [BW-1:0]      mplier_init;

    logic               enc_zero;
    logic               enc_two;
    logic               enc_neg;
    digit_sel_e         sel;
    logic [AW-1:0]      pp;

    booth_r4_digit_enc u_enc (
        .triplet_i (mplier_q[2:0]),
        .zero_o    (enc_zero),
        .two_o     (enc_two),
        .neg_o     (enc_neg)
    );

    // Extension bits: sign bit in signed mode, zero otherwise; the multiplier carries b[-1]=0.
    always_comb begin
        mcand_init  = {{(AW - WIDTH){signed_op & a[WIDTH-1]}}, a};
        mplier_init = {{2{signed_op & b[WIDTH-1]}}, b, 1'b0};
    end

    always_comb begin
        sel = digit_sel(enc_zero, enc_two, enc_neg);
        case (sel)
            ZERO:    pp = '0;
            POS1:    pp = mcand_q;
            POS2:    pp = {mcand_q[AW-2:0], 1'b0};
            NEG1:    pp = ~mcand_q + AW'(1);
            NEG2:    pp = ~{mcand_q[AW-2:0], 1'b0} + AW'(1);
            default: pp = '0;
        endcase
    end

    // Shifting the multiplicand by two each digit realises the 4^k weight of digit k.
    always_comb begin
        acc_d    = acc_q + pp;
        mcand_d  = {mcand_q[AW-3:0], 2'b00};
        mplier_d = mplier_q >> 2;
        cnt_d    = cnt_q + CW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= ITER;
                        busy_q   <= 1'b1;
                        mcand_q  <= mcand_init;
                        mplier_q <= mplier_init;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                ITER: begin
                    if (cnt_q == CW'(N)) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        product_q <= acc_q[2*WIDTH-1:0];
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_d;
                        mplier_q <= mplier_d;
                        cnt_q    <= cnt_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
